// File: rtl/pool_relu_wrapper_block.sv
// Four independent lanes of 2x2 stride-2 max pooling followed by ReLU on raster-order streams.
// Odd rows fill a per-lane line buffer; even rows pool against it and emit one result per column pair.
//
// phase   | meaning
// PH_ODD  | first row of a pair: store samples in the line buffer, no output
// PH_EVEN | second row: even column latches a partial max, odd column emits a result
module pool_relu_wrapper_block #(
  parameter int In_d_W = 32,
  parameter int W      = 26
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [3:0]            in_valid,
  input  logic [4*In_d_W-1:0]   in_data,
  output logic [3:0]            out_valid,
  output logic [4*In_d_W-1:0]   out_data
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [0:0]    PH_ODD   = 1'b0;
  localparam logic [0:0]    PH_EVEN  = 1'b1;
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);

  genvar k;
  for (k = 0; k < 4; k++) begin : g_lane
    logic [CW-1:0]             col;
    logic [0:0]                phase;
    logic signed [In_d_W-1:0]  partial;
    logic signed [In_d_W-1:0]  din;
    logic signed [In_d_W-1:0]  lb;
    logic signed [In_d_W-1:0]  m01;
    logic signed [In_d_W-1:0]  m;
    logic signed [In_d_W-1:0]  res;
    logic signed [In_d_W-1:0]  linebuf [W];
    logic                      vld;
    logic [In_d_W-1:0]         dout;

    assign din = in_data[k*In_d_W +: In_d_W];
    assign lb  = linebuf[col];

    always_comb begin
      m01 = (lb > din) ? lb : din;
      m   = (partial > m01) ? partial : m01;
      res = m[In_d_W-1] ? '0 : m;
    end

    // Buffer is never cleared: the next odd row rewrites every entry before it is read.
    always_ff @(posedge clk) begin
      if (in_valid[k] && phase == PH_ODD)
        linebuf[col] <= din;
    end

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        col     <= '0;
        phase   <= PH_ODD;
        partial <= '0;
        vld     <= 1'b0;
        dout    <= '0;
      end else begin
        vld <= 1'b0;
        if (in_valid[k]) begin
          col <= (col == COL_LAST) ? '0 : col + 1'b1;
          if (col == COL_LAST)
            phase <= ~phase;
          if (phase == PH_EVEN) begin
            if (!col[0]) begin
              partial <= m01;
            end else begin
              dout <= res;
              vld  <= 1'b1;
            end
          end
        end
      end
    end

    assign out_valid[k]                     = vld;
    assign out_data[k*In_d_W +: In_d_W]     = dout;
  end

endmodule

// File: tb/tb_pool_relu_wrapper_block.sv
// Directed and randomized checks of the four-lane 2x2 max-pool + ReLU block (W=26, 32-bit lanes).
module tb_pool_relu_wrapper_block;
  localparam int DW = 32;
  localparam int WD = 26;

  logic            clk = 1'b0;
  logic            clr = 1'b0;
  logic [3:0]      in_valid = '0;
  logic [4*DW-1:0] in_data = '0;
  logic [3:0]      out_valid;
  logic [4*DW-1:0] out_data;

  int checks = 0;
  int errors = 0;

  pool_relu_wrapper_block #(.In_d_W(DW), .W(WD)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Drive one cycle of input; returns #1 after the accepting edge.
  task automatic step(input logic [3:0] v, input logic [3:0][DW-1:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    in_valid = '0;
    clr = 1'b1;
    #2;
    clr = 1'b0;
  endtask

  function automatic int lane_out(input int k);
    logic signed [DW-1:0] s;
    s = out_data[k*DW +: DW];
    return int'(s);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic test_reset();
    clr = 1'b1;
    #3;
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_valid got %b want 0000", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      errors++; $display("FAIL reset_data got %h want 0", out_data);
    end
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Odd row 1..26, even row -1..-26 on all lanes; results 2,4,..,26.
  task automatic row_pair_check(input string name, input bit gaps);
    logic [3:0][DW-1:0] d;
    logic [3:0][DW-1:0] junk;
    int strobes = 0;
    for (int k = 0; k < 4; k++) junk[k] = 32'h7fff_fff0;
    for (int i = 0; i < WD; i++) begin
      for (int k = 0; k < 4; k++) d[k] = DW'(i + 1);
      step(4'hF, d);
      checks++;
      if (out_valid !== 4'b0000) begin
        errors++; $display("FAIL %s odd_row_valid col %0d got %b want 0000", name, i, out_valid);
      end
      if (gaps) begin
        step(4'h0, junk);
        checks++;
        if (out_valid !== 4'b0000) begin
          errors++; $display("FAIL %s gap_valid odd col %0d got %b want 0000", name, i, out_valid);
        end
      end
    end
    for (int i = 0; i < WD; i++) begin
      for (int k = 0; k < 4; k++) d[k] = DW'(-(i + 1));
      step(4'hF, d);
      checks++;
      if (out_valid !== ((i % 2 == 1) ? 4'hF : 4'h0)) begin
        errors++; $display("FAIL %s even_row_valid col %0d got %b", name, i, out_valid);
      end
      if (i % 2 == 1) begin
        strobes++;
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (lane_out(k) !== i + 1) begin
            errors++; $display("FAIL %s result lane %0d col %0d got %0d want %0d", name, k, i, lane_out(k), i + 1);
          end
        end
      end
      if (gaps) begin
        step(4'h0, junk);
        checks++;
        if (out_valid !== 4'b0000) begin
          errors++; $display("FAIL %s gap_valid even col %0d got %b want 0000", name, i, out_valid);
        end
        if (i % 2 == 1) begin
          checks++;
          if (lane_out(1) !== i + 1) begin
            errors++; $display("FAIL %s hold lane 1 col %0d got %0d want %0d", name, i, lane_out(1), i + 1);
          end
        end
      end
    end
    checks++;
    if (strobes != WD / 2) begin
      errors++; $display("FAIL %s strobe_count got %0d want %0d", name, strobes, WD / 2);
    end
  endtask

  task automatic test_row_pair();
    row_pair_check("row_pair", 1'b0);
  endtask

  task automatic test_gaps();
    row_pair_check("gaps", 1'b1);
  endtask

  task automatic test_relu();
    logic [3:0][DW-1:0] d;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < WD; i++) begin
        d[0] = DW'(7); d[1] = DW'(7); d[2] = DW'(-5); d[3] = DW'(7);
        step(4'hF, d);
        if (r == 1 && i % 2 == 1) begin
          checks++;
          if (out_valid[2] !== 1'b1 || lane_out(2) !== 0) begin
            errors++; $display("FAIL relu lane2 col %0d got v=%b d=%0d want v=1 d=0", i, out_valid[2], lane_out(2));
          end
          checks++;
          if (lane_out(0) !== 7) begin
            errors++; $display("FAIL relu lane0 col %0d got %0d want 7", i, lane_out(0));
          end
        end
      end
    end
  endtask

  task automatic test_signed_max();
    logic [3:0][DW-1:0] d;
    int odd_row [4]  = '{-10, 3, -10, -9};
    int even_row [4] = '{-7, -1, -8, -2};
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < WD; i++) begin
        for (int k = 0; k < 4; k++)
          d[k] = (i < 4) ? DW'((r == 0) ? odd_row[i] : even_row[i]) : DW'(r == 0 ? 0 : -1);
        step(4'hF, d);
        if (r == 1 && i == 1) begin
          checks++;
          if (out_valid[0] !== 1'b1 || lane_out(0) !== 3) begin
            errors++; $display("FAIL signed_max win0 got v=%b d=%0d want v=1 d=3", out_valid[0], lane_out(0));
          end
        end
        if (r == 1 && i == 3) begin
          checks++;
          if (out_valid[0] !== 1'b1 || lane_out(0) !== 0) begin
            errors++; $display("FAIL signed_max win1 got v=%b d=%0d want v=1 d=0", out_valid[0], lane_out(0));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_row();
    logic [3:0][DW-1:0] d;
    for (int i = 0; i < WD; i++) begin
      for (int k = 0; k < 4; k++) d[k] = DW'(50 + i);
      step(4'hF, d);
    end
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 4; k++) d[k] = DW'(-3);
      step(4'hF, d);
    end
    @(negedge clk);
    in_valid = 4'h0;
    clr = 1'b1;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || out_data !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got v=%b d=%h want 0", out_valid, out_data);
    end
    #1;
    clr = 1'b0;
    row_pair_check("after_reset", 1'b0);
  endtask

  task automatic test_random();
    logic [3:0][DW-1:0] d;
    int ob [4][WD];
    int pe [4];
    int x, e;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < WD; i++) begin
        for (int k = 0; k < 4; k++) begin
          x = int'($urandom_range(20)) - 10;
          d[k] = DW'(x);
          if (r == 0) ob[k][i] = x;
          else if (i % 2 == 0) pe[k] = x;
        end
        step(4'hF, d);
        if (r == 1 && i % 2 == 1) begin
          for (int k = 0; k < 4; k++) begin
            e = imax(imax(ob[k][i-1], ob[k][i]), imax(pe[k], int'($signed(d[k]))));
            if (e < 0) e = 0;
            checks++;
            if (out_valid[k] !== 1'b1 || lane_out(k) !== e || lane_out(k) < 0 || lane_out(k) > 10) begin
              errors++; $display("FAIL random lane %0d col %0d got v=%b d=%0d want %0d", k, i, out_valid[k], lane_out(k), e);
            end
          end
        end
      end
    end
  endtask

  // Random per-lane strobes; each lane tracked by its own position model.
  task automatic test_independent();
    logic [3:0][DW-1:0] d;
    logic [3:0] v;
    int ob [4][WD];
    int cc [4] = '{0, 0, 0, 0};
    bit ev [4] = '{0, 0, 0, 0};
    int pt [4] = '{0, 0, 0, 0};
    int last [4] = '{0, 0, 0, 0};
    bit xv [4];
    int x;
    pulse_clr();
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 4; k++) begin
        v[k] = ($urandom_range(k + 1) != 0);
        x = int'($urandom_range(20)) - 10;
        d[k] = DW'(x);
        xv[k] = 1'b0;
        if (v[k]) begin
          if (!ev[k]) ob[k][cc[k]] = x;
          else if (cc[k] % 2 == 0) pt[k] = imax(ob[k][cc[k]], x);
          else begin
            last[k] = imax(pt[k], imax(ob[k][cc[k]], x));
            if (last[k] < 0) last[k] = 0;
            xv[k] = 1'b1;
          end
          if (cc[k] == WD - 1) begin cc[k] = 0; ev[k] = !ev[k]; end
          else cc[k] = cc[k] + 1;
        end
      end
      step(v, d);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (out_valid[k] !== xv[k] || lane_out(k) !== last[k]) begin
          errors++; $display("FAIL independent n %0d lane %0d got v=%b d=%0d want v=%b d=%0d", n, k, out_valid[k], lane_out(k), xv[k], last[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_row_pair();
    test_relu();
    test_signed_max();
    test_gaps();
    test_reset_mid_row();
    test_random();
    test_independent();
    @(negedge clk);
    in_valid = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
